count_expand: RTL and testbench
===============================

# count_expand

Bit-serial count expander: the inverse of the team's combinational 4-input ones-counter. Accepts a 3-bit ones-count over a valid/ready handshake and emits a FRAME_BITS-bit frame, LSB first, that contains exactly that many ones in thermometer order (ones first). Sits between count-domain datapaths and serial links. Feeding each emitted frame back through the ones-counter reproduces the original count, which gives a round-trip check.

## Interface
- FRAME_BITS, 4: bits per emitted frame; legal range 1..7.
- CW, 3: count width; must satisfy 2**CW > FRAME_BITS.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- in_valid  in  1  count offered.
- in_ready  out  1  block can take a count this cycle.
- in_count  in  CW  number of ones to emit (0..FRAME_BITS; larger values are clamped).
- out_valid  out  1  out_bit carries a frame bit.
- out_ready  in  1  sink takes out_bit this cycle.
- out_bit  out  1  current serial bit.
- out_first  out  1  out_bit is frame bit 0.
- out_last  out  1  out_bit is frame bit FRAME_BITS-1.
- ovf  out  1  one-cycle pulse: the accepted count was clamped.

## Operation
- States:
  - IDLE: no frame held.
  - SHIFT: frame in progress. Registers are n (latched count), idx (0..FRAME_BITS-1).
- Accept event: in_valid && in_ready at a rising edge.
  - Latches n = min(in_count, FRAME_BITS).
  - Sets idx = 0 and enters SHIFT.
- Frame bits:
  - out_bit = (idx < n).
  - out_first = (idx == 0).
  - out_last = (idx == FRAME_BITS-1).
  - out_valid = 1 throughout SHIFT.
- Bit transfer: out_valid && out_ready at a rising edge.
  - If idx < FRAME_BITS-1: idx increments.
  - Else, with a new accept in the same edge: reload n, idx = 0, stay in SHIFT (back-to-back frames).
  - Else: go to IDLE.
- in_ready = rst_n && (state==IDLE || (out_last && out_ready)). It is combinational and is the only path from out_ready to in_ready.
- Stall: while out_ready is low, out_bit, out_first, out_last, idx and n hold.
- Clamp: if in_count > FRAME_BITS on accept, ovf pulses high for the following cycle only. A clamped accept during a back-to-back reload also pulses ovf.
- Ones count: the number of 1s emitted per frame always equals the clamped n.
- FRAME_BITS == 1: out_first and out_last are both high on the single bit.

## Timing
- Reset (rst_n low, asynchronous):
  - State IDLE; n = 0; idx = 0.
  - out_valid = 0, out_bit = 0, out_first = 0, out_last = 0, ovf = 0, in_ready = 0.
  - After release, in_ready = 1 in the first cycle.
- Latency: accept at edge k makes out_valid high with bit 0 in the cycle after edge k.
- Throughput:
  - With out_ready held high, one frame per FRAME_BITS cycles.
  - No idle cycle between back-to-back frames.
- Reset mid-frame aborts the frame at once. No partial completion and no ovf after release.
- in_count is sampled only on accept. Changes at other times are ignored.
- Outputs out_bit, out_first, out_last, out_valid and ovf are registered. in_ready is the only combinational output.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n low mid-frame for count 3 (after 2 bits out).
  - Response: out_valid drops asynchronously; every output at its reset value; after release, in_ready = 1 and no stale bits appear.
- Basic frames:
  - Stimulus: with out_ready = 1, send counts 0, 2 and 4 one at a time.
  - Response: bit streams 0000, 1100 and 1111 (LSB first); each starts 1 cycle after accept; out_first on bit 0 and out_last on bit 3.
- Back-to-back:
  - Stimulus: hold in_valid = 1 with counts 1 then 3 and out_ready = 1.
  - Response: 8 consecutive valid cycles carrying 1000 then 1110; in_ready is high only in IDLE and on out_last cycles.
- Backpressure:
  - Stimulus: count 2; drop out_ready for 3 cycles while bit 1 is presented.
  - Response: out_bit = 1, idx and out_first/out_last frozen during the stall; frame completes as 1100; total valid cycles = 4 + 3.
- Clamp:
  - Stimulus: in_count = 6 and 7, with FRAME_BITS = 4.
  - Response: each frame is 1111; ovf high for exactly one cycle after each accept; ovf low for counts 0..4.
- Round trip:
  - Stimulus: 200 random counts in 0..4 with random in_valid/out_ready; regroup each frame's 4 bits into the ones-counter.
  - Response: the counter's {c1,c0,s} equals the sent count on every frame.

Source files
------------

// File: rtl/count_expand.sv
// count_expand: bit-serial count expander.
// Takes a ones-count over a valid/ready handshake and emits a FRAME_BITS-bit
// thermometer frame, LSB first, with ones first. Counts above FRAME_BITS are
// clamped, and ovf flags the clamp for one cycle.
module count_expand #(
   parameter int FRAME_BITS = 4,
   parameter int CW         = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic          out_first,
   output logic          out_last,
   output logic          ovf
);

   localparam logic [CW-1:0] FB   = CW'(FRAME_BITS);
   localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state;
   logic [CW-1:0] n;
   logic [CW-1:0] idx;
   logic [CW-1:0] idx_inc;
   logic [CW-1:0] n_load;
   logic          too_big;
   logic          accept;
   logic          xfer;

   // A new count can be taken when idle, or on the edge that retires the
   // last bit of the current frame, so back-to-back frames have no gap.
   // Holding in_ready low during reset keeps a stale in_valid from landing.
   assign in_ready = rst_n && (state == IDLE || (out_last && out_ready));
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign too_big  = in_count > FB;
   assign n_load   = too_big ? FB : in_count;
   assign idx_inc  = idx + CW'(1);

   // Frame sequencer. Outputs are computed from the next idx/n values so that
   // every frame-facing output comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         n         <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         ovf <= 1'b0;
         if (accept) begin
            // Covers both a fresh start from IDLE and a reload on the last bit.
            state     <= SHIFT;
            n         <= n_load;
            idx       <= '0;
            out_valid <= 1'b1;
            out_bit   <= (n_load != '0);
            out_first <= 1'b1;
            out_last  <= (FRAME_BITS == 1);
            ovf       <= too_big;
         end else if (xfer) begin
            if (idx != LAST) begin
               idx       <= idx_inc;
               out_bit   <= (idx_inc < n);
               out_first <= 1'b0;
               out_last  <= (idx_inc == LAST);
            end else begin
               state     <= IDLE;
               idx       <= '0;
               out_valid <= 1'b0;
               out_bit   <= 1'b0;
               out_first <= 1'b0;
               out_last  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_count_expand.sv
// Directed bench for count_expand (FRAME_BITS = 4), with a random round-trip
// phase that feeds every frame through a ones-count model.
module tb_count_expand;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_count;
   logic       out_valid;
   logic       out_ready;
   logic       out_bit;
   logic       out_first;
   logic       out_last;
   logic       ovf;

   int nvec = 0;
   int nerr = 0;

   count_expand #(.FRAME_BITS(4), .CW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_count  (in_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bit   (out_bit),
      .out_first (out_first),
      .out_last  (out_last),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Called at posedge+1; offers count c and lets it be accepted.
   task automatic offer(input int c);
      in_valid  = 1'b1;
      in_count  = 3'(c);
      out_ready = 1'b1;
      #1;
      chk("offer_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Called at posedge+1 just after an accept; checks one 4-bit frame with
   // out_ready high. nv/nc are held on the input side during the frame.
   task automatic emit(input logic [3:0] exp, input int eovf, input logic nv, input int nc);
      for (int i = 0; i < 4; i++) begin
         in_valid  = nv;
         in_count  = 3'(nc);
         out_ready = 1'b1;
         #1;
         chk("emit_valid", int'(out_valid), 1);
         chk("emit_bit",   int'(out_bit),   int'(exp[i]));
         chk("emit_first", int'(out_first), (i == 0) ? 1 : 0);
         chk("emit_last",  int'(out_last),  (i == 3) ? 1 : 0);
         chk("emit_ovf",   int'(ovf),       (i == 0) ? eovf : 0);
         chk("emit_ready", int'(in_ready),  (i == 3) ? 1 : 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int vcnt;
      int sent;
      int checked;
      int cyc;
      int ones;
      int cur;
      logic pend;
      int q[$];

      rst_n = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_bit",   int'(out_bit),   0);
      chk("rst_first", int'(out_first), 0);
      chk("rst_last",  int'(out_last),  0);
      chk("rst_ovf",   int'(ovf),       0);
      chk("rst_ready", int'(in_ready),  0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", int'(in_ready), 1);

      // Basic frames: 0 -> 0000, 2 -> 1100, 4 -> 1111 (LSB first)
      offer(0); emit(4'b0000, 0, 1'b0, 0);
      chk("idle_valid0", int'(out_valid), 0);
      offer(2); emit(4'b0011, 0, 1'b0, 0);
      offer(4); emit(4'b1111, 0, 1'b0, 0);
      chk("idle_valid4", int'(out_valid), 0);

      // Back-to-back: 1 then 3, in_valid held high
      in_valid = 1'b1; in_count = 3'd1; out_ready = 1'b1;
      #1; chk("b2b_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      emit(4'b0001, 0, 1'b1, 3);
      emit(4'b0111, 0, 1'b0, 0);
      chk("b2b_end", int'(out_valid), 0);

      // Backpressure: count 2, stall 3 cycles on bit 1
      offer(2);
      vcnt = 0;
      out_ready = 1'b1; #1;
      chk("bp_bit0", int'(out_bit), 1);
      chk("bp_first0", int'(out_first), 1);
      vcnt += int'(out_valid);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         out_ready = 1'b0; #1;
         chk("bp_st_valid", int'(out_valid), 1);
         chk("bp_st_bit",   int'(out_bit),   1);
         chk("bp_st_first", int'(out_first), 0);
         chk("bp_st_last",  int'(out_last),  0);
         chk("bp_st_ready", int'(in_ready),  0);
         vcnt += int'(out_valid);
         @(posedge clk); #1;
      end
      for (int i = 1; i < 4; i++) begin
         out_ready = 1'b1; #1;
         chk("bp_bit",  int'(out_bit),  (i == 1) ? 1 : 0);
         chk("bp_last", int'(out_last), (i == 3) ? 1 : 0);
         vcnt += int'(out_valid);
         @(posedge clk); #1;
      end
      chk("bp_vcnt", vcnt, 7);
      chk("bp_end", int'(out_valid), 0);

      // Clamp: 6 and 7 both give 1111 with a one-cycle ovf
      offer(6); emit(4'b1111, 1, 1'b0, 0);
      chk("clamp_ovf_after6", int'(ovf), 0);
      offer(7); emit(4'b1111, 1, 1'b0, 0);
      chk("clamp_ovf_after7", int'(ovf), 0);

      // Reset mid-frame: count 3, reset after 2 bits
      offer(3);
      for (int i = 0; i < 2; i++) begin
         out_ready = 1'b1; #1;
         chk("mid_bit", int'(out_bit), 1);
         @(posedge clk); #1;
      end
      #1; rst_n = 1'b0; #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_bit",   int'(out_bit),   0);
      chk("mid_rst_first", int'(out_first), 0);
      chk("mid_rst_last",  int'(out_last),  0);
      chk("mid_rst_ovf",   int'(ovf),       0);
      chk("mid_rst_ready", int'(in_ready),  0);
      @(posedge clk); #1;
      rst_n = 1'b1; #1;
      chk("mid_rel_ready", int'(in_ready), 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mid_no_stale", int'(out_valid), 0);
         chk("mid_no_ovf",   int'(ovf),       0);
      end

      // Round trip: random counts 0..4, random in_valid/out_ready
      sent = 0; checked = 0; cyc = 0; ones = 0; cur = 0; pend = 1'b0;
      while (checked < 200 && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (!pend && sent < 200 && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            cur  = int'($urandom_range(0, 4));
         end
         in_valid  = pend;
         in_count  = 3'(cur);
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            q.push_back(cur);
            sent++;
            pend = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (out_first) ones = 0;
            ones += int'(out_bit);
            if (out_last) begin
               if (q.size() == 0) chk("rt_queue_empty", 1, 0);
               else chk("rt_count", ones, q.pop_front());
               checked++;
            end
         end
      end
      in_valid = 1'b0;
      if (checked < 200) chk("rt_timeout", checked, 200);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
